// File: rtl/dc_tag_sched.sv
// Data-cache tag search scheduler: arbitrates core load/store requests, walks the
// ways of one set through the tag bank, and issues a fill request to L2 on a miss.
module dc_tag_sched #(
  parameter int unsigned WAYS     = 8,
  parameter int unsigned TAG_BITS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coretodc_ld_valid,
  output logic                coretodc_ld_retry,
  input  logic [TAG_BITS-1:0] coretodc_ld_tag,
  input  logic [4:0]          coretodc_ld_index,
  input  logic                coretodc_std_valid,
  output logic                coretodc_std_retry,
  input  logic [TAG_BITS-1:0] coretodc_std_tag,
  input  logic [4:0]          coretodc_std_index,
  output logic                tag_req_valid,
  output logic [7:0]          tag_req_pos,
  input  logic                tag_ack_valid,
  input  logic [TAG_BITS+4:0] tag_ack_data,
  output logic                l1tol2_req_valid,
  input  logic                l1tol2_req_retry,
  output logic [2:0]          l1tol2_req,
  input  logic                l2tol1_snack_valid,
  input  logic [4:0]          l2tol1_snack,
  output logic                done_valid,
  output logic                done_hit,
  output logic [2:0]          done_way
);

  localparam logic [2:0] SC_CMD_REQ_S  = 3'd1;
  localparam logic [2:0] SC_CMD_REQ_M  = 3'd2;
  localparam logic [4:0] SC_SCMD_ACK_S = 5'd1;
  localparam logic [4:0] SC_SCMD_ACK_E = 5'd2;
  localparam logic [4:0] SC_SCMD_ACK_M = 5'd3;
  localparam logic [2:0] LAST_WAY      = 3'(WAYS - 1);

  typedef enum logic [2:0] {IDLE, SEARCH, L2REQ, L2WAIT, DONE} state_t;

  state_t              state;
  logic                rr_st;
  logic                is_st;
  logic [TAG_BITS-1:0] lat_tag;
  logic [4:0]          lat_index;
  logic [2:0]          way;
  logic [2:0]          victim;
  logic                inv_found;
  logic                rrip_found;
  logic                grant_ld;
  logic                grant_st;
  logic [TAG_BITS-1:0] ack_tag;
  logic [1:0]          ack_rrip;
  logic [2:0]          ack_state;
  logic                ack_hit;
  logic                snack_is_ack;

  assign ack_tag      = tag_ack_data[TAG_BITS-1:0];
  assign ack_rrip     = tag_ack_data[TAG_BITS+1:TAG_BITS];
  assign ack_state    = tag_ack_data[TAG_BITS+4:TAG_BITS+2];
  assign ack_hit      = (ack_tag == lat_tag) && (ack_state != 3'd0);
  assign snack_is_ack = (l2tol1_snack == SC_SCMD_ACK_S) || (l2tol1_snack == SC_SCMD_ACK_E) ||
                        (l2tol1_snack == SC_SCMD_ACK_M);

  // rr_st=1 favours the store; the pointer only moves when both requesters compete.
  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (!reset && state == IDLE) begin
      if (coretodc_ld_valid && coretodc_std_valid) begin
        grant_ld = ~rr_st;
        grant_st = rr_st;
      end else begin
        grant_ld = coretodc_ld_valid;
        grant_st = coretodc_std_valid;
      end
    end
  end

  assign coretodc_ld_retry  = !reset && coretodc_ld_valid  && !grant_ld;
  assign coretodc_std_retry = !reset && coretodc_std_valid && !grant_st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr_st            <= 1'b0;
      is_st            <= 1'b0;
      lat_tag          <= '0;
      lat_index        <= '0;
      way              <= '0;
      victim           <= '0;
      inv_found        <= 1'b0;
      rrip_found       <= 1'b0;
      tag_req_valid    <= 1'b0;
      tag_req_pos      <= '0;
      l1tol2_req_valid <= 1'b0;
      l1tol2_req       <= '0;
      done_valid       <= 1'b0;
      done_hit         <= 1'b0;
      done_way         <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ld || grant_st) begin
            is_st         <= grant_st;
            lat_tag       <= grant_st ? coretodc_std_tag : coretodc_ld_tag;
            lat_index     <= grant_st ? coretodc_std_index : coretodc_ld_index;
            way           <= '0;
            victim        <= '0;
            inv_found     <= 1'b0;
            rrip_found    <= 1'b0;
            tag_req_valid <= 1'b1;
            tag_req_pos   <= {(grant_st ? coretodc_std_index : coretodc_ld_index), 3'd0};
            if (coretodc_ld_valid && coretodc_std_valid) rr_st <= ~rr_st;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          tag_req_valid <= 1'b0;
          if (tag_ack_valid) begin
            if (ack_hit) begin
              done_hit   <= 1'b1;
              done_way   <= way;
              done_valid <= 1'b1;
              state      <= DONE;
            end else begin
              // An invalid way always beats an RRIP==3 candidate, even one seen earlier.
              if (ack_state == 3'd0) begin
                if (!inv_found) begin
                  victim    <= way;
                  inv_found <= 1'b1;
                end
              end else if (!inv_found && !rrip_found && ack_rrip == 2'd3) begin
                victim     <= way;
                rrip_found <= 1'b1;
              end
              if (way == LAST_WAY) begin
                l1tol2_req_valid <= 1'b1;
                l1tol2_req       <= is_st ? SC_CMD_REQ_M : SC_CMD_REQ_S;
                state            <= L2REQ;
              end else begin
                way           <= way + 3'd1;
                tag_req_valid <= 1'b1;
                tag_req_pos   <= {lat_index, way + 3'd1};
              end
            end
          end
        end
        L2REQ: begin
          if (!l1tol2_req_retry) begin
            l1tol2_req_valid <= 1'b0;
            state            <= L2WAIT;
          end
        end
        L2WAIT: begin
          if (l2tol1_snack_valid && snack_is_ack) begin
            done_hit   <= 1'b0;
            done_way   <= victim;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_tag_sched.sv
// Scoreboard bench for dc_tag_sched: tag-bank and L2 models plus a done monitor.
module tb_dc_tag_sched;

  localparam logic [2:0] REQ_S = 3'd1;
  localparam logic [2:0] REQ_M = 3'd2;
  localparam logic [4:0] ACK_S = 5'd1;
  localparam logic [4:0] ACK_E = 5'd2;
  localparam logic [4:0] ACK_M = 5'd3;

  typedef struct packed {logic hit; logic [2:0] way;} done_t;
  typedef struct packed {logic [2:0] cmd; logic [7:0] cycles;} l2_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_retry, std_valid, std_retry;
  logic [9:0]  ld_tag, std_tag;
  logic [4:0]  ld_index, std_index;
  logic        tag_req_valid;
  logic [7:0]  tag_req_pos;
  logic        tag_ack_valid;
  logic [14:0] tag_ack_data;
  logic        l1tol2_req_valid, l1tol2_req_retry;
  logic [2:0]  l1tol2_req;
  logic        snack_valid;
  logic [4:0]  snack;
  logic        done_valid, done_hit;
  logic [2:0]  done_way;

  int checks = 0;
  int errors = 0;
  int l2_hs = 0;
  int l2_retry_cycles = 0;
  logic [14:0] mem [8];
  done_t exp_done[$];
  logic [7:0] exp_pos[$];
  l2_t exp_l2[$];

  always #5 clk = ~clk;

  dc_tag_sched #(.WAYS(8), .TAG_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .coretodc_ld_valid(ld_valid), .coretodc_ld_retry(ld_retry),
    .coretodc_ld_tag(ld_tag), .coretodc_ld_index(ld_index),
    .coretodc_std_valid(std_valid), .coretodc_std_retry(std_retry),
    .coretodc_std_tag(std_tag), .coretodc_std_index(std_index),
    .tag_req_valid(tag_req_valid), .tag_req_pos(tag_req_pos),
    .tag_ack_valid(tag_ack_valid), .tag_ack_data(tag_ack_data),
    .l1tol2_req_valid(l1tol2_req_valid), .l1tol2_req_retry(l1tol2_req_retry),
    .l1tol2_req(l1tol2_req),
    .l2tol1_snack_valid(snack_valid), .l2tol1_snack(snack),
    .done_valid(done_valid), .done_hit(done_hit), .done_way(done_way)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_tag_req_valid"}, 32'(tag_req_valid), 0);
    check({tag, "_tag_req_pos"}, 32'(tag_req_pos), 0);
    check({tag, "_l2_valid"}, 32'(l1tol2_req_valid), 0);
    check({tag, "_l2_req"}, 32'(l1tol2_req), 0);
    check({tag, "_done_valid"}, 32'(done_valid), 0);
    check({tag, "_done_hit"}, 32'(done_hit), 0);
    check({tag, "_done_way"}, 32'(done_way), 0);
    check({tag, "_ld_retry"}, 32'(ld_retry), 0);
    check({tag, "_std_retry"}, 32'(std_retry), 0);
  endtask

  task automatic set_way(input int w, input logic [2:0] st, input logic [1:0] rrip,
                         input logic [9:0] tag);
    mem[w] = {st, rrip, tag};
  endtask

  task automatic fill_mem(input logic [2:0] st, input logic [1:0] rrip, input logic [9:0] tag);
    for (int w = 0; w < 8; w++) set_way(w, st, rrip, tag);
  endtask

  task automatic push_pos(input logic [4:0] idx);
    for (int w = 0; w < 8; w++) exp_pos.push_back({idx, 3'(w)});
  endtask

  task automatic issue(input logic st, input logic [9:0] tag, input logic [4:0] idx);
    @(posedge clk); #1;
    if (st) begin std_valid = 1'b1; std_tag = tag; std_index = idx; end
    else    begin ld_valid = 1'b1; ld_tag = tag; ld_index = idx; end
    @(negedge clk);
    check(st ? "std_accept" : "ld_accept", 32'(st ? std_retry : ld_retry), 0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    std_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (exp_done.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (exp_done.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done pulse, required %0d", name, exp_done.size());
      exp_done.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_hs(input int prev, input string name);
    int c;
    c = 0;
    while (l2_hs == prev && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (l2_hs == prev) begin
      checks++; errors++;
      $display("FAIL %s_l2_timeout: got no L2 handshake, required 1", name);
    end
  endtask

  task automatic send_snack(input logic [4:0] code);
    @(posedge clk); #1;
    snack_valid = 1'b1;
    snack = code;
    @(posedge clk); #1;
    snack_valid = 1'b0;
    snack = '0;
  endtask

  // Tag bank: one-cycle ack, one cycle after the request is seen.
  initial begin
    logic [14:0] d;
    tag_ack_valid = 1'b0;
    tag_ack_data = '0;
    forever begin
      @(negedge clk);
      if (tag_req_valid) begin
        if (exp_pos.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tag_req: got pos %0d, required none", tag_req_pos);
        end else check("tag_req_pos", 32'(tag_req_pos), 32'(exp_pos.pop_front()));
        d = mem[tag_req_pos[2:0]];
        @(posedge clk); #1;
        tag_ack_valid = 1'b1;
        tag_ack_data = d;
        @(posedge clk); #1;
        tag_ack_valid = 1'b0;
      end
    end
  end

  // L2 model: retry for l2_retry_cycles cycles, then record how long the request was held.
  initial begin
    int cnt;
    l2_t cur;
    cnt = 0;
    cur = '0;
    l1tol2_req_retry = 1'b0;
    forever begin
      @(negedge clk);
      if (l1tol2_req_valid) begin
        cnt++;
        if (cnt == 1) begin
          if (exp_l2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_l2_req: got cmd %0d, required none", l1tol2_req);
          end else cur = exp_l2.pop_front();
        end
        check("l2_cmd", 32'(l1tol2_req), 32'(cur.cmd));
        l1tol2_req_retry = (cnt <= l2_retry_cycles);
      end else if (cnt > 0) begin
        check("l2_hold_cycles", cnt, 32'(cur.cycles));
        cnt = 0;
        l1tol2_req_retry = 1'b0;
        l2_hs++;
      end
    end
  end

  // Done monitor: every pulse must match the oldest outstanding expectation.
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (done_valid) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got hit=%0d way=%0d, required no pulse", done_hit, done_way);
        end else begin
          e = exp_done.pop_front();
          check("done_hit", 32'(done_hit), 32'(e.hit));
          check("done_way", 32'(done_way), 32'(e.way));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int grants;
    reset = 1'b1;
    ld_valid = 1'b1; std_valid = 1'b1;
    ld_tag = '0; std_tag = '0; ld_index = '0; std_index = '0;
    snack_valid = 1'b0; snack = '0;
    fill_mem(3'd1, 2'd0, 10'h000);
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    ld_valid = 1'b0; std_valid = 1'b0;
    reset = 1'b0;

    // Load hit in way 2; way 1 matches the tag but is invalid.
    set_way(0, 3'd1, 2'd0, 10'h100);
    set_way(1, 3'd0, 2'd0, 10'h155);
    set_way(2, 3'd2, 2'd1, 10'h155);
    exp_pos.push_back(8'd24); exp_pos.push_back(8'd25); exp_pos.push_back(8'd26);
    exp_done.push_back('{hit: 1'b1, way: 3'd2});
    issue(1'b0, 10'h155, 5'd3);
    wait_done("ld_hit");
    repeat (3) @(negedge clk);
    check("hold_done_hit", 32'(done_hit), 1);
    check("hold_done_way", 32'(done_way), 2);

    // Store miss: way 2 RRIP==3 but way 5 invalid wins; L2 retries 3 cycles.
    fill_mem(3'd1, 2'd0, 10'h000);
    set_way(2, 3'd1, 2'd3, 10'h000);
    set_way(5, 3'd0, 2'd0, 10'h000);
    push_pos(5'd10);
    l2_retry_cycles = 3;
    exp_l2.push_back('{cmd: REQ_M, cycles: 8'd4});
    exp_done.push_back('{hit: 1'b0, way: 3'd5});
    prev = l2_hs;
    issue(1'b1, 10'h2AA, 5'd10);
    wait_hs(prev, "st_miss");
    send_snack(ACK_M);
    wait_done("st_miss");

    // Load miss, no invalid way, RRIP==3 in ways 4 and 6.
    fill_mem(3'd2, 2'd1, 10'h000);
    set_way(4, 3'd2, 2'd3, 10'h000);
    set_way(6, 3'd2, 2'd3, 10'h000);
    push_pos(5'd31);
    l2_retry_cycles = 0;
    exp_l2.push_back('{cmd: REQ_S, cycles: 8'd1});
    exp_done.push_back('{hit: 1'b0, way: 3'd4});
    prev = l2_hs;
    issue(1'b0, 10'h155, 5'd31);
    wait_hs(prev, "ld_rrip");
    send_snack(ACK_E);
    wait_done("ld_rrip");

    // Non-ACK snack ignored; expectation is queued only once ACK_S is on its way.
    fill_mem(3'd3, 2'd0, 10'h000);
    push_pos(5'd0);
    exp_l2.push_back('{cmd: REQ_S, cycles: 8'd1});
    prev = l2_hs;
    issue(1'b0, 10'h0F0, 5'd0);
    wait_hs(prev, "nack");
    send_snack(5'd7);
    repeat (3) @(negedge clk);
    exp_done.push_back('{hit: 1'b0, way: 3'd0});
    send_snack(ACK_S);
    wait_done("nack");

    // Snack in IDLE ignored; reset during L2WAIT abandons the request.
    send_snack(ACK_S);
    repeat (3) @(negedge clk);
    push_pos(5'd4);
    exp_l2.push_back('{cmd: REQ_S, cycles: 8'd1});
    prev = l2_hs;
    issue(1'b0, 10'h0F0, 5'd4);
    wait_hs(prev, "rst_l2wait");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    send_snack(ACK_S);
    repeat (4) @(negedge clk);
    check_reset_outs("post_reset");

    // Both valid: load first (reset pointer), then store via round-robin.
    fill_mem(3'd1, 2'd0, 10'h000);
    set_way(0, 3'd1, 2'd0, 10'h011);
    set_way(3, 3'd1, 2'd0, 10'h022);
    exp_pos.push_back(8'd8);
    for (int w = 0; w < 4; w++) exp_pos.push_back({5'd2, 3'(w)});
    exp_done.push_back('{hit: 1'b1, way: 3'd0});
    exp_done.push_back('{hit: 1'b1, way: 3'd3});
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_tag = 10'h011; ld_index = 5'd1;
    std_valid = 1'b1; std_tag = 10'h022; std_index = 5'd2;
    grants = 0;
    for (int c = 0; c < 300 && grants < 2; c++) begin
      @(negedge clk);
      if (!ld_retry || !std_retry) begin
        if (grants == 0) begin
          check("grant1_ld_retry", 32'(ld_retry), 0);
          check("grant1_std_retry", 32'(std_retry), 1);
          grants = 1;
          @(negedge clk);
          check("busy_ld_retry", 32'(ld_retry), 1);
          check("busy_std_retry", 32'(std_retry), 1);
        end else begin
          check("grant2_std_retry", 32'(std_retry), 0);
          check("grant2_ld_retry", 32'(ld_retry), 1);
          grants = 2;
          @(posedge clk); #1;
          ld_valid = 1'b0;
          std_valid = 1'b0;
        end
      end
    end
    check("grant_count", grants, 2);
    ld_valid = 1'b0;
    std_valid = 1'b0;
    wait_done("rr");

    repeat (3) @(negedge clk);
    check("pos_queue_empty", exp_pos.size(), 0);
    check("l2_queue_empty", exp_l2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_tag_sched.md
DC_TAG_SCHED -- requirements
Module: dc_tag_sched

Interface
REQ-001 Parameter: WAYS, 8, associativity; fixed at 8, since the way number is 3 bits and the position is index*8+way.
REQ-002 Parameter: TAG_BITS, 10, tag compare width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 coretodc_ld_valid  in  1  core load request valid.
REQ-006 coretodc_ld_retry  out  1  load not accepted this cycle.
REQ-007 coretodc_ld_tag  in  10  load tag.
REQ-008 coretodc_ld_index  in  5  load set index.
REQ-009 coretodc_std_valid  in  1  core store request valid.
REQ-010 coretodc_std_retry  out  1  store not accepted this cycle.
REQ-011 coretodc_std_tag  in  10  store tag.
REQ-012 coretodc_std_index  in  5  store set index.
REQ-013 tag_req_valid  out  1  tag-bank read request.
REQ-014 tag_req_pos  out  8  tag-bank entry address, index*8+way.
REQ-015 tag_ack_valid  in  1  tag-bank read data valid.
REQ-016 tag_ack_data  in  15  fields: [9:0] tag, [11:10] RRIP counter, [14:12] line state (0 = I).
REQ-017 l1tol2_req_valid  out  1  miss request to L2.
REQ-018 l1tol2_req_retry  in  1  L2 stall.
REQ-019 l1tol2_req  out  3  miss command: SC_CMD_REQ_S for a load, SC_CMD_REQ_M for a store.
REQ-020 l2tol1_snack_valid  in  1  L2 response valid.
REQ-021 l2tol1_snack  in  5  L2 response code.
REQ-022 done_valid  out  1  one-cycle completion pulse.
REQ-023 done_hit  out  1  1 = hit, 0 = miss (filled from L2).
REQ-024 done_way  out  3  hit way, or chosen victim way on a miss.

Function
REQ-025 FSM states: IDLE, SEARCH, L2REQ, L2WAIT, DONE.
REQ-026 Acceptance: accept only in IDLE; in every other state both retry outputs are 1 whenever their valid is 1.
REQ-027 Arbitration in IDLE, round-robin pointer, reset value = load first:
  - both valid: grant the favoured requester, assert retry on the other, then toggle the pointer.
  - single valid: grant it; the pointer is unchanged.
REQ-028 On grant: latch tag, index and type (ld/st); way counter = 0; victim-found flag cleared; next state SEARCH.
REQ-029 SEARCH request: drive tag_req_valid=1 and tag_req_pos={index,way}; at most one read outstanding; the next request is issued only after tag_ack_valid.
REQ-030 SEARCH response, on tag_ack_valid:
  - hit = tag_ack_data[9:0]==latched tag AND state!=0.
  - on hit: done_way=way, done_hit=1, next state DONE.
REQ-031 Victim selection, evaluated during SEARCH in ascending way order:
  - first way with state==0;
  - else first way with RRIP==3;
  - else way 0.
REQ-032 On a miss at way 7, the next state is L2REQ; the way counter must not wrap into another search.
REQ-033 L2REQ: l1tol2_req_valid=1 with a stable command; advance to L2WAIT in the first cycle where l1tol2_req_retry=0.
REQ-034 L2WAIT, on l2tol1_snack_valid:
  - code SC_SCMD_ACK_S, SC_SCMD_ACK_E or SC_SCMD_ACK_M: done_hit=0, done_way=victim, next state DONE.
  - any other code is ignored.
REQ-035 A snack arriving outside L2WAIT is ignored; a tag_ack_valid arriving outside SEARCH is ignored.
REQ-036 DONE: done_valid=1 for exactly one cycle, next state IDLE; a new request may be accepted in the following cycle.
REQ-037 done_hit and done_way hold their values until the next DONE.

Reset
REQ-038 While reset is asserted:
  - FSM = IDLE, round-robin pointer = load;
  - tag_req_valid, l1tol2_req_valid, done_valid, done_hit, both retries = 0;
  - tag_req_pos, l1tol2_req, done_way = 0.
REQ-039 Reset asserted mid-search or mid-L2 wait abandons the operation with no done pulse; a late ack or snack after reset is ignored.

Verification
REQ-040 Load, tag 0x155, index 3, hit in way 2 -> tag_req_pos 24,25,26; done_valid after the third ack; done_hit=1; done_way=2.
REQ-041 Store misses all 8 ways, way 5 invalid, L2 retry held 3 cycles then ACK_M -> l1tol2_req=SC_CMD_REQ_M held 4 cycles; done_hit=0; done_way=5.
REQ-042 Load misses, no invalid way, RRIP==3 in ways 4 and 6 -> SC_CMD_REQ_S issued; done_way=4.
REQ-043 Load and store valid together for two back-to-back grants -> load granted first with std_retry=1; store granted second; retries asserted while busy.
REQ-044 Reset asserted in L2WAIT, then an ACK_S snack arrives -> state IDLE, no done_valid, all outputs at reset values.
REQ-045 Snack with a non-ACK code in L2WAIT, then ACK_S -> done pulse only after ACK_S.
